// File: rtl/instaweb_link_arbiter.sv
// Per-output round-robin link arbiter for the topology relay.
// Each outbound link locks to one inbound link for a whole packet. The mux
// selects are registered. The valid/ready handshake is combinational from the
// lock state, and a hold watchdog frees outputs whose owner has stalled.
module instaweb_link_arbiter #(
   parameter int unsigned NEIGHBORS = 8,
   parameter int unsigned PW        = 3,
   parameter int unsigned MAX_HOLD  = 255
) (
   input  logic                      clk_synce,
   input  logic                      rst_n,
   input  logic                      route_enable,
   input  logic [NEIGHBORS-1:0]      in_valid,
   input  logic [NEIGHBORS*PW-1:0]   in_dest,
   input  logic [NEIGHBORS-1:0]      in_last,
   output logic [NEIGHBORS-1:0]      in_ready,
   output logic [NEIGHBORS*PW-1:0]   out_src,
   output logic [NEIGHBORS-1:0]      out_valid,
   input  logic [NEIGHBORS-1:0]      out_ready,
   output logic [NEIGHBORS-1:0]      hold_err,
   input  logic                      err_clr
);

   // Stall counter only needs to count 0..MAX_HOLD-1
   localparam int unsigned  HCW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HCW-1:0] HOLD_LIMIT = HCW'(MAX_HOLD - 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   state_e               state_q    [NEIGHBORS];
   state_e               state_d    [NEIGHBORS];
   logic [PW-1:0]        owner_q    [NEIGHBORS];
   logic [PW-1:0]        owner_d    [NEIGHBORS];
   logic [PW-1:0]        rr_ptr_q   [NEIGHBORS];
   logic [PW-1:0]        rr_ptr_d   [NEIGHBORS];
   logic [HCW-1:0]       hold_cnt_q [NEIGHBORS];
   logic [HCW-1:0]       hold_cnt_d [NEIGHBORS];
   logic [NEIGHBORS-1:0] hold_err_q;
   logic [NEIGHBORS-1:0] hold_err_d;

   logic [PW-1:0]        dest       [NEIGHBORS];
   logic [NEIGHBORS-1:0] xfer;

   // Unpack the per-link destination fields
   always_comb begin
      for (int unsigned i = 0; i < NEIGHBORS; i++) begin
         dest[i] = in_dest[i*PW +: PW];
      end
   end

   // Handshake: a locked output passes its owner's beat only while the owner still targets it
   always_comb begin
      out_valid = '0;
      in_ready  = '0;
      xfer      = '0;
      for (int unsigned j = 0; j < NEIGHBORS; j++) begin
         if (state_q[j] == ST_LOCKED && dest[owner_q[j]] == PW'(j)) begin
            out_valid[j]          = in_valid[owner_q[j]];
            in_ready[owner_q[j]]  = in_ready[owner_q[j]] | out_ready[j];
            xfer[j]               = in_valid[owner_q[j]] & out_ready[j];
         end
      end
   end

   // Next-state: round-robin grant in IDLE, packet tracking and watchdog in LOCKED
   always_comb begin
      hold_err_d = err_clr ? '0 : hold_err_q;
      for (int unsigned j = 0; j < NEIGHBORS; j++) begin
         logic          found;
         int unsigned   win_idx;
         int unsigned   idx;
         logic [PW-1:0] cand;

         state_d[j]    = state_q[j];
         owner_d[j]    = owner_q[j];
         rr_ptr_d[j]   = rr_ptr_q[j];
         hold_cnt_d[j] = hold_cnt_q[j];
         found         = 1'b0;
         win_idx       = 0;
         idx           = 0;
         cand          = '0;

         case (state_q[j])
            ST_IDLE: begin
               if (route_enable) begin
                  for (int unsigned k = 0; k < NEIGHBORS; k++) begin
                     idx = 32'(rr_ptr_q[j]) + k;
                     if (idx >= NEIGHBORS) begin
                        idx = idx - NEIGHBORS;
                     end
                     cand = PW'(idx);
                     if (!found && in_valid[cand] && dest[cand] == PW'(j)) begin
                        found   = 1'b1;
                        win_idx = idx;
                     end
                  end
               end
               if (found) begin
                  state_d[j]    = ST_LOCKED;
                  owner_d[j]    = PW'(win_idx);
                  rr_ptr_d[j]   = PW'((win_idx + 1) % NEIGHBORS);
                  hold_cnt_d[j] = '0;
               end
            end
            ST_LOCKED: begin
               if (xfer[j]) begin
                  hold_cnt_d[j] = '0;
                  if (in_last[owner_q[j]]) begin
                     state_d[j] = ST_IDLE;
                  end
               end else if (hold_cnt_q[j] == HOLD_LIMIT) begin
                  state_d[j]    = ST_IDLE;
                  hold_cnt_d[j] = '0;
                  hold_err_d[j] = 1'b1;
               end else begin
                  hold_cnt_d[j] = HCW'(hold_cnt_q[j] + 1'b1);
               end
            end
            default: begin
               state_d[j] = ST_IDLE;
            end
         endcase
      end
   end

   // State registers; reset abandons any in-flight packet
   always_ff @(posedge clk_synce or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned j = 0; j < NEIGHBORS; j++) begin
            state_q[j]    <= ST_IDLE;
            owner_q[j]    <= '0;
            rr_ptr_q[j]   <= '0;
            hold_cnt_q[j] <= '0;
         end
         hold_err_q <= '0;
      end else begin
         for (int unsigned j = 0; j < NEIGHBORS; j++) begin
            state_q[j]    <= state_d[j];
            owner_q[j]    <= owner_d[j];
            rr_ptr_q[j]   <= rr_ptr_d[j];
            hold_cnt_q[j] <= hold_cnt_d[j];
         end
         hold_err_q <= hold_err_d;
      end
   end

   // Mux select is the registered owner; it keeps the last owner after release
   always_comb begin
      for (int unsigned j = 0; j < NEIGHBORS; j++) begin
         out_src[j*PW +: PW] = owner_q[j];
      end
      hold_err = hold_err_q;
   end

endmodule

// File: tb/tb_instaweb_link_arbiter.sv
// Directed bench for instaweb_link_arbiter (watchdog limit shortened to 4).
// Inputs change 1 ns after the rising edge and outputs are sampled on the falling edge.
module tb_instaweb_link_arbiter;

   localparam int unsigned N  = 8;
   localparam int unsigned PW = 3;
   localparam int unsigned MH = 4;

   logic            clk_synce = 1'b0;
   logic            rst_n;
   logic            route_enable;
   logic [N-1:0]    in_valid;
   logic [N*PW-1:0] in_dest;
   logic [N-1:0]    in_last;
   logic [N-1:0]    in_ready;
   logic [N*PW-1:0] out_src;
   logic [N-1:0]    out_valid;
   logic [N-1:0]    out_ready;
   logic [N-1:0]    hold_err;
   logic            err_clr;

   int checks = 0;
   int errors = 0;

   instaweb_link_arbiter #(.NEIGHBORS(N), .PW(PW), .MAX_HOLD(MH)) dut (
      .clk_synce    (clk_synce),
      .rst_n        (rst_n),
      .route_enable (route_enable),
      .in_valid     (in_valid),
      .in_dest      (in_dest),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .out_src      (out_src),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .hold_err     (hold_err),
      .err_clr      (err_clr)
   );

   always #5 clk_synce = ~clk_synce;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   task automatic drive_cycle();
      @(posedge clk_synce);
      #1;
   endtask

   task automatic sample();
      @(negedge clk_synce);
   endtask

   task automatic set_dest(input int i, input int d);
      in_dest[i*PW +: PW] = PW'(d);
   endtask

   task automatic clear_inputs();
      in_valid  = '0;
      in_last   = '0;
      in_dest   = '0;
      out_ready = '0;
      err_clr   = 1'b0;
   endtask

   function automatic logic [PW-1:0] src_of(input int j);
      return out_src[j*PW +: PW];
   endfunction

   task automatic test_reset();
      rst_n        = 1'b0;
      route_enable = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk_synce);
      sample();
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL reset_out_valid got %h want 00", out_valid); end
      checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL reset_in_ready got %h want 00", in_ready); end
      checks++; if (out_src !== 24'h0) begin errors++; $display("FAIL reset_out_src got %h want 000000", out_src); end
      checks++; if (hold_err !== 8'h00) begin errors++; $display("FAIL reset_hold_err got %h want 00", hold_err); end
      drive_cycle();
      rst_n        = 1'b1;
      route_enable = 1'b1;
   endtask

   task automatic test_contention();
      int exp_src [3] = '{0, 3, 5};
      set_dest(0, 2); set_dest(3, 2); set_dest(5, 2);
      in_valid  = 8'b0010_1001;
      in_last   = 8'hFF;
      out_ready = 8'h04;
      sample();
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL cont_grant_valid got %h want 00", out_valid); end
      checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL cont_grant_ready got %h want 00", in_ready); end
      for (int k = 0; k < 3; k++) begin
         drive_cycle();
         sample();
         checks++; if (src_of(2) !== PW'(exp_src[k])) begin errors++; $display("FAIL cont_src[%0d] got %0d want %0d", k, src_of(2), exp_src[k]); end
         checks++; if (out_valid !== 8'h04) begin errors++; $display("FAIL cont_valid[%0d] got %h want 04", k, out_valid); end
         checks++; if (in_ready !== N'(1 << exp_src[k])) begin errors++; $display("FAIL cont_ready[%0d] got %h want %h", k, in_ready, N'(1 << exp_src[k])); end
         drive_cycle();
         in_valid[exp_src[k]] = 1'b0;
         sample();
         checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL cont_bubble[%0d] got %h want 00", k, out_valid); end
      end
      // Pointer should now sit at 6: link 6 beats link 0
      drive_cycle();
      set_dest(6, 2);
      in_valid = 8'b0100_0001;
      sample();
      drive_cycle();
      in_valid = 8'b0100_0000;
      sample();
      checks++; if (src_of(2) !== 3'd6) begin errors++; $display("FAIL cont_rr_ptr6 got %0d want 6", src_of(2)); end
      checks++; if (in_ready !== 8'h40) begin errors++; $display("FAIL cont_rr_ready got %h want 40", in_ready); end
      drive_cycle();
      clear_inputs();
      drive_cycle();
   endtask

   task automatic test_lock();
      set_dest(1, 4); set_dest(2, 4);
      in_valid  = 8'b0000_0110;
      in_last   = '0;
      out_ready = 8'h10;
      sample();
      checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL lock_grant_ready got %h want 00", in_ready); end
      for (int b = 1; b <= 4; b++) begin
         drive_cycle();
         in_last[1] = (b == 4);
         sample();
         checks++; if (src_of(4) !== 3'd1) begin errors++; $display("FAIL lock_src_beat%0d got %0d want 1", b, src_of(4)); end
         checks++; if (out_valid !== 8'h10) begin errors++; $display("FAIL lock_valid_beat%0d got %h want 10", b, out_valid); end
         checks++; if (in_ready !== 8'h02) begin errors++; $display("FAIL lock_ready_beat%0d got %h want 02", b, in_ready); end
      end
      drive_cycle();
      in_valid[1] = 1'b0;
      in_last     = '0;
      sample();
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL lock_rearb_valid got %h want 00", out_valid); end
      drive_cycle();
      in_last[2] = 1'b1;
      sample();
      checks++; if (src_of(4) !== 3'd2) begin errors++; $display("FAIL lock_next_src got %0d want 2", src_of(4)); end
      checks++; if (in_ready !== 8'h04) begin errors++; $display("FAIL lock_next_ready got %h want 04", in_ready); end
      drive_cycle();
      clear_inputs();
      drive_cycle();
   endtask

   task automatic test_backpressure();
      logic rdy [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int   beats = 0;
      set_dest(6, 0);
      in_valid  = 8'h40;
      in_last   = '0;
      out_ready = '0;
      sample();
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL bp_grant_valid got %h want 00", out_valid); end
      for (int c = 0; c < 4; c++) begin
         drive_cycle();
         out_ready[0] = rdy[c];
         in_last[6]   = (beats == 1);
         sample();
         checks++; if (out_valid !== 8'h01) begin errors++; $display("FAIL bp_valid[%0d] got %h want 01", c, out_valid); end
         checks++; if (in_ready[6] !== rdy[c]) begin errors++; $display("FAIL bp_ready[%0d] got %b want %b", c, in_ready[6], rdy[c]); end
         if (in_valid[6] && in_ready[6]) beats++;
      end
      checks++; if (beats != 2) begin errors++; $display("FAIL bp_beats got %0d want 2", beats); end
      checks++; if (hold_err !== 8'h00) begin errors++; $display("FAIL bp_hold_err got %h want 00", hold_err); end
      drive_cycle();
      in_valid = '0;
      sample();
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL bp_release got %h want 00", out_valid); end
      clear_inputs();
      drive_cycle();
   endtask

   task automatic test_watchdog();
      set_dest(7, 3);
      in_valid  = 8'h80;
      in_last   = '0;
      out_ready = 8'h08;
      sample();
      drive_cycle();
      sample();
      checks++; if (in_ready !== 8'h80) begin errors++; $display("FAIL wd_first_beat got %h want 80", in_ready); end
      drive_cycle();
      in_valid = '0;
      for (int s = 0; s < 4; s++) begin
         sample();
         checks++; if (hold_err !== 8'h00) begin errors++; $display("FAIL wd_stall[%0d] got %h want 00", s, hold_err); end
         drive_cycle();
      end
      set_dest(2, 3);
      in_valid = 8'h04;
      in_last  = 8'h04;
      sample();
      checks++; if (hold_err !== 8'h08) begin errors++; $display("FAIL wd_hold_err got %h want 08", hold_err); end
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL wd_idle got %h want 00", out_valid); end
      drive_cycle();
      sample();
      checks++; if (src_of(3) !== 3'd2) begin errors++; $display("FAIL wd_regrant got %0d want 2", src_of(3)); end
      checks++; if (hold_err !== 8'h08) begin errors++; $display("FAIL wd_sticky got %h want 08", hold_err); end
      drive_cycle();
      in_valid = '0;
      in_last  = '0;
      err_clr  = 1'b1;
      sample();
      checks++; if (hold_err !== 8'h08) begin errors++; $display("FAIL wd_before_clr got %h want 08", hold_err); end
      drive_cycle();
      err_clr = 1'b0;
      sample();
      checks++; if (hold_err !== 8'h00) begin errors++; $display("FAIL wd_cleared got %h want 00", hold_err); end
      clear_inputs();
      drive_cycle();
   endtask

   task automatic test_parallel_gating();
      set_dest(0, 1); set_dest(1, 0);
      in_valid  = 8'h03;
      in_last   = 8'h03;
      out_ready = 8'h03;
      sample();
      drive_cycle();
      sample();
      checks++; if (out_valid !== 8'h03) begin errors++; $display("FAIL par_valid got %h want 03", out_valid); end
      checks++; if (in_ready !== 8'h03) begin errors++; $display("FAIL par_ready got %h want 03", in_ready); end
      checks++; if (src_of(0) !== 3'd1) begin errors++; $display("FAIL par_src0 got %0d want 1", src_of(0)); end
      checks++; if (src_of(1) !== 3'd0) begin errors++; $display("FAIL par_src1 got %0d want 0", src_of(1)); end
      drive_cycle();
      clear_inputs();
      route_enable = 1'b0;
      set_dest(4, 6);
      in_valid  = 8'h10;
      in_last   = 8'h10;
      out_ready = 8'h40;
      for (int c = 0; c < 3; c++) begin
         sample();
         checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL gate_valid[%0d] got %h want 00", c, out_valid); end
         checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL gate_ready[%0d] got %h want 00", c, in_ready); end
         drive_cycle();
      end
      route_enable = 1'b1;
      sample();
      checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL gate_grant_ready got %h want 00", in_ready); end
      drive_cycle();
      sample();
      checks++; if (src_of(6) !== 3'd4) begin errors++; $display("FAIL gate_src got %0d want 4", src_of(6)); end
      checks++; if (in_ready !== 8'h10) begin errors++; $display("FAIL gate_ready_on got %h want 10", in_ready); end
      drive_cycle();
      clear_inputs();
      drive_cycle();
   endtask

   task automatic test_reset_mid_packet();
      // Output 7 stalls until the watchdog fires, so hold_err is set before reset
      set_dest(0, 7);
      in_valid  = 8'h01;
      in_last   = '0;
      out_ready = '0;
      repeat (4) drive_cycle();
      set_dest(4, 5);
      in_valid     = 8'h11;
      out_ready[5] = 1'b1;
      drive_cycle();
      in_valid = 8'h10;
      sample();
      checks++; if (hold_err !== 8'h80) begin errors++; $display("FAIL rst_pre_hold_err got %h want 80", hold_err); end
      checks++; if (in_ready !== 8'h10) begin errors++; $display("FAIL rst_beat1_ready got %h want 10", in_ready); end
      drive_cycle();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL rst_mid_valid got %h want 00", out_valid); end
      checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL rst_mid_ready got %h want 00", in_ready); end
      checks++; if (hold_err !== 8'h00) begin errors++; $display("FAIL rst_mid_hold_err got %h want 00", hold_err); end
      checks++; if (out_src !== 24'h0) begin errors++; $display("FAIL rst_mid_out_src got %h want 000000", out_src); end
      drive_cycle();
      drive_cycle();
      rst_n = 1'b1;
      set_dest(2, 5); set_dest(6, 5);
      in_valid = 8'h44;
      in_last  = 8'h44;
      sample();
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL rst_post_grant got %h want 00", out_valid); end
      drive_cycle();
      sample();
      checks++; if (src_of(5) !== 3'd2) begin errors++; $display("FAIL rst_ptr_zero got %0d want 2", src_of(5)); end
      checks++; if (in_ready !== 8'h04) begin errors++; $display("FAIL rst_post_ready got %h want 04", in_ready); end
      drive_cycle();
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_contention();
      test_lock();
      test_backpressure();
      test_watchdog();
      test_parallel_gating();
      test_reset_mid_packet();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
